// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg : shared types for the UART transmit arbiter            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_priority_pick : round-robin one-hot pick starting at ptr          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any
);

  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_first;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_rot[j] = req[(j + int'(ptr)) % NREQ];
    end
  end

  assign w_first = w_rot & (~w_rot + NREQ'(1));

  always_comb begin
    pick = '0;
    for (int j = 0; j < NREQ; j++) begin
      pick[(j + int'(ptr)) % NREQ] = w_first[j];
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : message-granular round-robin share of UART TX      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      tx_tdata,
  output logic                   tx_tvalid,
  input  logic                   tx_tready,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t          r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;

  logic [NREQ-1:0]     w_pick;
  logic                w_any;
  logic [PTR_W-1:0]    w_owner;
  logic [BYTE_W-1:0]   w_odata;
  logic                w_olast;
  logic                w_room;
  logic                w_accept;
  logic                w_release;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;

  rr_priority_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  // Decode the one-hot grant into an index and mux the owner's byte.
  always_comb begin
    w_owner = '0;
    w_odata = '0;
    w_olast = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        w_owner = PTR_W'(i);
        w_odata = req_data[i*BYTE_W +: BYTE_W];
        w_olast = req_last[i];
      end
    end
  end

  assign w_room    = ~tx_tvalid | tx_tready;
  assign req_ready = (r_state == ARB_OWN && w_room) ? grant : '0;
  assign w_accept  = |(req_ready & req_valid);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_release = w_accept && (w_olast || w_cnt_nxt == CNT_W'(MAX_BURST));
  assign w_ptr_nxt = (w_owner == PTR_W'(NREQ - 1)) ? '0 : w_owner + PTR_W'(1);
  assign busy      = (r_state == ARB_OWN) | tx_tvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      grant     <= '0;
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
    end else begin
      // Output register: a fresh accept wins over a drain in the same cycle.
      if (w_accept) begin
        tx_tdata  <= w_odata;
        tx_tvalid <= 1'b1;
      end else if (tx_tready) begin
        tx_tvalid <= 1'b0;
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            grant   <= w_pick;
            r_cnt   <= '0;
            r_state <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_release) begin
              grant   <= '0;
              r_ptr   <= w_ptr_nxt;
              r_state <= ARB_IDLE;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      tx_tdata;
  logic            tx_tvalid;
  logic            tx_tready;
  logic [NREQ-1:0] grant;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] dq [NREQ][$];
  logic [7:0] exp_q [$];
  logic [NREQ-1:0] acc;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .grant     (grant),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic send(input int r, input logic [7:0] b, input logic last, input bit expect_out);
    dq[r].push_back({last, b});
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic flush_all();
    for (int i = 0; i < NREQ; i++) dq[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int pend;
    pend = 1;
    for (int k = 0; k < 300 && pend != 0; k++) begin
      @(negedge clk);
      pend = exp_q.size() + int'(tx_tvalid);
      for (int i = 0; i < NREQ; i++) pend += dq[i].size();
    end
    chk(name, pend, 0);
  endtask

  // Requester driver: present queue heads after negedge, note accepts just before posedge.
  initial begin
    logic [8:0] h;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    acc       = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && dq[i].size() > 0) h = dq[i].pop_front();
        if (dq[i].size() > 0) begin
          h = dq[i][0];
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = h[7:0];
          req_last[i]        = h[8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      #3;
      acc = req_valid & req_ready;
    end
  end

  // Monitor: each UART handshake must match the next expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && tx_tvalid && tx_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", tx_tdata);
        end else begin
          e = exp_q.pop_front();
          if (tx_tdata !== e) begin
            errors++;
            $display("FAIL tx_byte actual=%0h required=%0h", tx_tdata, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] tr2 [9];
    reset     = 1'b1;
    tx_tready = 1'b0;
    tr2 = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_tvalid", tx_tvalid, 0);
    chk("rst_tdata", tx_tdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Single requester, 3-byte message.
    tx_tready = 1'b1;
    send(1, 8'h41, 1'b0, 1'b1);
    send(1, 8'h42, 1'b0, 1'b1);
    send(1, 8'h43, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_grant", grant, (k < 3) ? 4'b0010 : 4'b0000);
    end
    wait_drain("t1_drain");

    // Requesters 0 and 2 contend with 2-byte messages.
    do_reset();
    tx_tready = 1'b1;
    send(0, 8'hA0, 1'b0, 1'b1);
    send(0, 8'hA1, 1'b1, 1'b1);
    send(2, 8'hC0, 1'b0, 1'b0);
    send(2, 8'hC1, 1'b1, 1'b0);
    send(0, 8'hA2, 1'b0, 1'b0);
    send(0, 8'hA3, 1'b1, 1'b0);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t2_grant_trace", grant, tr2[k]);
    end
    wait_drain("t2_drain");

    // Forced release after 16 bytes with no last.
    do_reset();
    tx_tready = 1'b1;
    for (int k = 0; k < 16; k++) send(0, 8'h10 + 8'(k), 1'b0, 1'b1);
    send(1, 8'h55, 1'b1, 1'b1);
    for (int k = 16; k < 20; k++) send(0, 8'h10 + 8'(k), 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    chk("t3_grant_b16", grant, 4'b0001);
    @(negedge clk);
    chk("t3_release", grant, 4'b0000);
    @(negedge clk);
    chk("t3_next_owner", grant, 4'b0010);
    wait_drain("t3_drain");

    // Back-pressure from the UART.
    do_reset();
    tx_tready = 1'b1;
    send(2, 8'hB0, 1'b0, 1'b1);
    send(2, 8'hB1, 1'b0, 1'b1);
    send(2, 8'hB2, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tx_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t4_hold_data", tx_tdata, 8'hB0);
      chk("t4_hold_ready", req_ready, 0);
      @(negedge clk);
    end
    tx_tready = 1'b1;
    #2;
    chk("t4_ready_on_rise", req_ready, 4'b0100);
    wait_drain("t4_drain");

    // Asynchronous reset mid-message; ptr should return to 0.
    @(negedge clk);
    tx_tready = 1'b0;
    send(1, 8'hD0, 1'b0, 1'b0);
    send(1, 8'hD1, 1'b0, 1'b0);
    send(1, 8'hD2, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_grant", grant, 4'b0010);
    @(negedge clk);
    chk("t5_tvalid", tx_tvalid, 1);
    #3;
    reset = 1'b1;
    flush_all();
    #1;
    chk("t5_rst_tvalid", tx_tvalid, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    tx_tready = 1'b1;
    send(3, 8'hE3, 1'b1, 1'b0);
    send(1, 8'hE1, 1'b1, 1'b1);
    exp_q.push_back(8'hE3);
    @(negedge clk);
    chk("t5_scan_from0", grant, 4'b0010);
    wait_drain("t5_drain");

    // Non-owner data must wait for its own grant.
    do_reset();
    tx_tready = 1'b1;
    send(1, 8'hF0, 1'b0, 1'b1);
    send(1, 8'hF1, 1'b0, 1'b1);
    send(1, 8'hF2, 1'b0, 1'b1);
    send(1, 8'hF3, 1'b1, 1'b1);
    @(negedge clk);
    send(3, 8'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk("t6_nonowner_ready", req_ready[3], 0);
      chk("t6_owner", grant, 4'b0010);
    end
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
